coupled_col_loader: RTL
=======================

Name: coupled_col_loader

Overview:
Programming and run sequencer for one column of the DIMPLE coupling matrix. It buffers host weight-write commands in a small FIFO and replays each one into the column's write port. It reads each weight back and checks it against the expected value. It holds the ring oscillators in reset (ising_rstn low) while weights change, and releases them for a programmed number of cycles on a start request.

Parameters:
N, 8, number of cells/spins in the column; valid cell address range 0..N-1
FIFO_DEPTH, 4, command FIFO entries; power of two, minimum 2
READ_LAT, 2, cycles between the write strobe and a valid col_rdata sample; minimum 1
RDATA_MASK, 32'hFFFFFFFF, bits of col_rdata compared against the written wdata

Ports:
clk  in  1  system clock
axi_rst  in  1  asynchronous active-high reset
cmd_valid  in  1  host command valid
cmd_ready  out  1  FIFO not full
cmd_s_addr  in  16  source cell address
cmd_d_addr  in  16  destination cell address
cmd_wdata  in  32  weight word
start  in  1  single-cycle run request
run_cycles  in  32  oscillator run length, sampled when RUN is entered
busy  out  1  state != IDLE, or FIFO non-empty
done  out  1  one-cycle pulse at end of run
err  out  1  sticky: verify mismatch or bad address; cleared only by reset
err_count  out  8  saturating count of failed commands
ising_rstn  out  1  oscillator reset to column, active low
col_wready  out  1  column write strobe
col_wr_match  out  1  column address-match enable
col_s_addr  out  16  column source address
col_d_addr  out  16  column destination address
col_wdata  out  32  column write data
col_rdata  in  32  column readback

Behaviour:
- Reset values:
  - state = IDLE; FIFO empty; cmd_ready = 1.
  - busy = 0, done = 0, err = 0, err_count = 0, ising_rstn = 0.
  - All col_* outputs = 0; start_pending = 0.
- FIFO:
  - Push on cmd_valid & cmd_ready; pop when IDLE dispatches an entry.
  - Push and pop in the same cycle are both allowed, including when the FIFO is full (cmd_ready = 1 in that case).
  - Pointers wrap modulo FIFO_DEPTH.
  - Commands pushed during RUN are buffered but not dispatched until RUN ends.
- IDLE:
  - If the FIFO is non-empty, pop the head into a command register.
    - If both addresses are >= N, set err, increment err_count, and stay in IDLE. No column activity.
    - Otherwise go to WRITE.
  - Else, if start or start_pending: go to RUN if run_cycles != 0, else go to DONE. Clear start_pending.
  - A start arriving while busy sets start_pending; repeated starts collapse into one.
- WRITE (1 cycle):
  - col_wready = 1 and col_wr_match = 1.
  - col_s_addr, col_d_addr and col_wdata driven from the command register.
  - Next state SETTLE.
- SETTLE (READ_LAT cycles):
  - col_wr_match = 1, col_wready = 0; addresses and wdata held.
  - Next state CHECK.
- CHECK (1 cycle):
  - col_wr_match = 1.
  - If (col_rdata & RDATA_MASK) != (wdata & RDATA_MASK): set err and increment err_count.
  - Next state IDLE.
- Write latency is fixed: 1 + READ_LAT + 1 cycles per command after the pop.
- Outside WRITE, SETTLE and CHECK: col_wready = col_wr_match = 0. Address and data outputs hold their last values.
- ising_rstn:
  - 0 in every state except RUN.
  - 1 in RUN for exactly run_cycles consecutive cycles, counted by an internal 32-bit down-counter loaded on RUN entry.
  - run_cycles changes during RUN are ignored.
- RUN: leave to DONE when the counter reaches 1.
- DONE (1 cycle): done = 1; next state IDLE.
- err_count saturates at 255.
- Reset asserted mid-operation:
  - Immediately forces the reset values.
  - In-flight command and FIFO contents are discarded.
  - ising_rstn drops to 0 asynchronously.

Test Plan:
- Reset behaviour: assert axi_rst mid-RUN with run_cycles=100 -> ising_rstn falls without waiting for clk; all outputs take their reset values; busy=0 after release.
- Single write: push s=2, d=3, wdata=32'h0000_0011, with col_rdata model echoing the stored weight -> col_wready high for exactly 1 cycle; col_wr_match high for 4 cycles (READ_LAT=2); err=0; busy falls 5 cycles after the push.
- Verify failure: col_rdata model returns 32'h0000_0010 for the same write -> err=1, err_count=1; the next good write leaves err_count=1.
- Bad address: push s=8, d=9 -> no col_wready and no col_wr_match; err=1, err_count increments.
- FIFO full: push 5 commands back-to-back with FIFO_DEPTH=4 -> cmd_ready deasserts when full; all 5 commands are written in order with correct addresses.
- Start sequencing:
  - start with 2 commands queued and run_cycles=10 -> both writes complete first, then ising_rstn is high for exactly 10 cycles, then done pulses for 1 cycle.
  - start with run_cycles=0 -> done pulses and ising_rstn never rises.

Source files
------------

// File: rtl/coupled_col_loader.sv
// Column programming/run sequencer for a DIMPLE coupling matrix: buffers weight writes,
// replays and verifies them, then releases the ring oscillators for a programmed run.
module coupled_col_loader #(
  parameter int unsigned N          = 8,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned READ_LAT   = 2,
  parameter logic [31:0] RDATA_MASK = 32'hFFFFFFFF
) (
  input  logic        clk_i,
  input  logic        axi_rst_i,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic [15:0] cmd_s_addr_i,
  input  logic [15:0] cmd_d_addr_i,
  input  logic [31:0] cmd_wdata_i,
  input  logic        start_i,
  input  logic [31:0] run_cycles_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  output logic [7:0]  err_count_o,
  output logic        ising_rstn_o,
  output logic        col_wready_o,
  output logic        col_wr_match_o,
  output logic [15:0] col_s_addr_o,
  output logic [15:0] col_d_addr_o,
  output logic [31:0] col_wdata_o,
  input  logic [31:0] col_rdata_i
);

  localparam int unsigned AW    = $clog2(FIFO_DEPTH);
  localparam logic [15:0] NAddr = 16'(N);

  typedef enum logic [2:0] {StIdle, StWrite, StSettle, StCheck, StRun, StDone} state_e;

  state_e        state_q, state_d;
  logic [AW:0]   wr_ptr_q, rd_ptr_q;
  logic [63:0]   mem_q [FIFO_DEPTH];
  logic [15:0]   cmd_s_q, cmd_d_q;
  logic [31:0]   cmd_w_q;
  logic [31:0]   cnt_q, cnt_d;
  logic          err_q;
  logic [7:0]    err_cnt_q;
  logic          start_pend_q, start_pend_d;
  logic          ising_rstn_q;

  logic          empty, full, push, pop, head_bad, load_cmd, err_set;
  logic [63:0]   head;

  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign head     = mem_q[rd_ptr_q[AW-1:0]];
  assign pop      = (state_q == StIdle) && !empty;
  // A pop frees a slot this cycle, so a full FIFO can still accept.
  assign cmd_ready_o = !full || pop;
  assign push     = cmd_valid_i && cmd_ready_o;
  assign head_bad = (head[63:48] >= NAddr) && (head[47:32] >= NAddr);

  assign busy_o         = (state_q != StIdle) || !empty;
  assign done_o         = (state_q == StDone);
  assign col_wready_o   = (state_q == StWrite);
  assign col_wr_match_o = (state_q == StWrite) || (state_q == StSettle) || (state_q == StCheck);
  assign col_s_addr_o   = cmd_s_q;
  assign col_d_addr_o   = cmd_d_q;
  assign col_wdata_o    = cmd_w_q;
  assign err_o          = err_q;
  assign err_count_o    = err_cnt_q;
  assign ising_rstn_o   = ising_rstn_q;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    load_cmd     = 1'b0;
    err_set      = 1'b0;
    start_pend_d = start_pend_q | (start_i & busy_o);
    unique case (state_q)
      StIdle: begin
        if (!empty) begin
          if (head_bad) begin
            err_set = 1'b1;
          end else begin
            load_cmd = 1'b1;
            state_d  = StWrite;
          end
        end else if (start_i || start_pend_q) begin
          start_pend_d = 1'b0;
          if (run_cycles_i != 32'd0) begin
            state_d = StRun;
            cnt_d   = run_cycles_i;
          end else begin
            state_d = StDone;
          end
        end
      end
      StWrite: begin
        state_d = StSettle;
        cnt_d   = 32'(READ_LAT);
      end
      StSettle: begin
        if (cnt_q <= 32'd1) state_d = StCheck;
        else                cnt_d   = cnt_q - 32'd1;
      end
      StCheck: begin
        if ((col_rdata_i & RDATA_MASK) != (cmd_w_q & RDATA_MASK)) err_set = 1'b1;
        state_d = StIdle;
      end
      StRun: begin
        if (cnt_q <= 32'd1) state_d = StDone;
        else                cnt_d   = cnt_q - 32'd1;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge axi_rst_i) begin
    if (axi_rst_i) begin
      state_q      <= StIdle;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      cmd_s_q      <= '0;
      cmd_d_q      <= '0;
      cmd_w_q      <= '0;
      cnt_q        <= '0;
      err_q        <= 1'b0;
      err_cnt_q    <= '0;
      start_pend_q <= 1'b0;
      ising_rstn_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      start_pend_q <= start_pend_d;
      ising_rstn_q <= (state_d == StRun);
      if (push) wr_ptr_q <= wr_ptr_q + (AW + 1)'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + (AW + 1)'(1);
      if (load_cmd) begin
        cmd_s_q <= head[63:48];
        cmd_d_q <= head[47:32];
        cmd_w_q <= head[31:0];
      end
      if (err_set) begin
        err_q <= 1'b1;
        if (err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= {cmd_s_addr_i, cmd_d_addr_i, cmd_wdata_i};
  end

endmodule
